// File: rtl/mesh_job_scheduler.sv
// Job sequencer for the mesh array: optional weight preload, one start pulse,
// fixed-latency wait, then hand-off of the captured result over valid/ready.
module mesh_job_scheduler #(
  parameter int DW          = 8,
  parameter int ROWS        = 12,
  parameter int COLS        = 14,
  parameter int ROW_W       = 4,
  parameter int COL_W       = 4,
  parameter int ACC_W       = 16,
  parameter int LAT_W       = 6,
  parameter int COMPUTE_LAT = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_reload,
  input  logic [COLS*DW-1:0]     cmd_x,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DW-1:0]          w_data,
  output logic                   preload_valid,
  output logic [ROW_W+COL_W-1:0] preload_addr,
  output logic [DW-1:0]          preload_data,
  output logic                   start,
  output logic [COLS*DW-1:0]     x_vector_flat,
  input  logic [ROWS*ACC_W-1:0]  result_flat,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ROWS*ACC_W-1:0]  res_data,
  output logic                   busy,
  output logic                   weights_loaded,
  output logic [2:0]             dbg_state
);

  // Handshakes (cmd, w, res): a transfer happens on the rising edge where valid
  // and ready are both high; ready depends only on state, never on valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(COMPUTE_LAT - 1);

  state_t                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic                    wl_q, wl_d;
  logic [COLS*DW-1:0]      x_q, x_d;
  logic                    pv_q, pv_d;
  logic [ROW_W+COL_W-1:0]  pa_q, pa_d;
  logic [DW-1:0]           pd_q, pd_d;
  logic                    rv_q, rv_d;
  logic [ROWS*ACC_W-1:0]   rd_q, rd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      lat_q   <= '0;
      wl_q    <= 1'b0;
      x_q     <= '0;
      pv_q    <= 1'b0;
      pa_q    <= '0;
      pd_q    <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      lat_q   <= lat_d;
      wl_q    <= wl_d;
      x_q     <= x_d;
      pv_q    <= pv_d;
      pa_q    <= pa_d;
      pd_q    <= pd_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    lat_d     = lat_q;
    wl_d      = wl_q;
    x_d       = x_q;
    pv_d      = 1'b0;
    pa_d      = pa_q;
    pd_d      = pd_q;
    rv_d      = rv_q;
    rd_d      = rd_q;
    cmd_ready = 1'b0;
    w_ready   = 1'b0;
    start     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Gated by rst so every output reads 0 while reset is held.
        cmd_ready = !rst;
        if (cmd_valid) begin
          x_d = cmd_x;
          if (cmd_reload || !wl_q) begin
            row_d   = '0;
            col_d   = '0;
            wl_d    = 1'b0;
            state_d = S_LOAD;
          end else begin
            // FLUSH doubles as the settle cycle, so start always lands two
            // cycles after the event that triggers it.
            state_d = S_FLUSH;
          end
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        if (w_valid) begin
          pv_d = 1'b1;
          pa_d = {row_q, col_q};
          pd_d = w_data;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_FLUSH;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        wl_d    = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        start   = 1'b1;
        lat_d   = LAT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          rd_d    = result_flat;
          rv_d    = 1'b1;
          state_d = S_OUT;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign preload_valid  = pv_q;
  assign preload_addr   = pa_q;
  assign preload_data   = pd_q;
  assign x_vector_flat  = x_q;
  assign res_valid      = rv_q;
  assign res_data       = rd_q;
  assign busy           = (state_q != S_IDLE);
  assign weights_loaded = wl_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mesh_job_scheduler.sv
// Directed bench for mesh_job_scheduler: preload ordering, start/result timing,
// result hold, async reset mid-load and back-to-back jobs.
module tb_mesh_job_scheduler;

  localparam int DW = 8, ROWS = 12, COLS = 14, ROW_W = 4, COL_W = 4;
  localparam int ACC_W = 16, LAT_W = 6, COMPUTE_LAT = 28;
  localparam int XW = COLS * DW;
  localparam int RW = ROWS * ACC_W;
  localparam int CW = RW;
  localparam int NBEATS = ROWS * COLS;

  localparam logic [XW-1:0] X1 = {14{8'h11}};
  localparam logic [XW-1:0] X2 = 112'h0f1e2d3c4b5a69788796a5b4c3d2;
  localparam logic [XW-1:0] X3 = {7{16'hbeef}};
  localparam logic [XW-1:0] X4 = {14{8'h5a}};
  localparam logic [XW-1:0] X5 = {{7{8'h80}}, {7{8'h7f}}};

  logic                   clk;
  logic                   rst;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_reload;
  logic [XW-1:0]          cmd_x;
  logic                   w_valid;
  logic                   w_ready;
  logic [DW-1:0]          w_data;
  logic                   preload_valid;
  logic [ROW_W+COL_W-1:0] preload_addr;
  logic [DW-1:0]          preload_data;
  logic                   start;
  logic [XW-1:0]          x_vector_flat;
  logic [RW-1:0]          result_flat;
  logic                   res_valid;
  logic                   res_ready;
  logic [RW-1:0]          res_data;
  logic                   busy;
  logic                   weights_loaded;
  logic [2:0]             dbg_state;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int overlap_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  mesh_job_scheduler #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
    .ACC_W(ACC_W), .LAT_W(LAT_W), .COMPUTE_LAT(COMPUTE_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reload(cmd_reload), .cmd_x(cmd_x),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .preload_valid(preload_valid), .preload_addr(preload_addr), .preload_data(preload_data),
    .start(start), .x_vector_flat(x_vector_flat), .result_flat(result_flat),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .weights_loaded(weights_loaded), .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Array stand-in: result carries the cycle it is sampled in plus the x vector.
  assign result_flat = {48'd0, 32'(cyc), x_vector_flat};

  // Preload bus monitor: {cycle, addr, data} per beat.
  always @(negedge clk) begin
    if (preload_valid) got_q.push_back({16'(cyc), preload_addr, preload_data});
    if (preload_valid && start) overlap_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] exp_res(input int s, input logic [XW-1:0] x);
    return {48'd0, 32'(s + COMPUTE_LAT), x};
  endfunction

  // Driver tasks: entered and left on a falling edge.
  task automatic send_cmd(input logic reload, input logic [XW-1:0] x, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_reload = reload;
    cmd_x = x;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_accept", CW'(cmd_ready), CW'(1));
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x = ~x;
  endtask

  task automatic load_weights(input int n, input int gap_pct, output int last_hs);
    int i;
    int guard;
    int r;
    i = 0;
    guard = 0;
    last_hs = -1;
    while (i < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      r = int'($urandom_range(99));
      w_valid = (r >= gap_pct);
      w_data = 8'(i);
      if (w_valid && w_ready) begin
        exp_q.push_back({16'(cyc + 1), 4'(i / COLS), 4'(i % COLS), 8'(i)});
        last_hs = cyc;
        i++;
      end
    end
    check_eq("load_beats", CW'(i), CW'(n));
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int sc);
    int n;
    n = 0;
    while (!start && n < budget) begin
      @(negedge clk);
      n++;
    end
    sc = start ? cyc : -1;
  endtask

  task automatic wait_res(input int budget, output int rc);
    int n;
    n = 0;
    while (!res_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    rc = res_valid ? cyc : -1;
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("res_release", CW'({res_valid, busy, cmd_ready}), CW'(3'b001));
  endtask

  // Scoreboard drain for the preload bus.
  task automatic compare_preload(input int n);
    check_eq("preload_count", CW'(got_q.size()), CW'(n));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check_eq("preload_beat", CW'(got_q.pop_front()), CW'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int acc, last, sc, rc;
    int n_acc, n_st, n_res;
    logic acc_flag;
    int st[3];
    logic [XW-1:0] bb_x[3];

    bb_x[0] = {14{8'h01}};
    bb_x[1] = {14{8'hc3}};
    bb_x[2] = {2{56'h0123456789abcd}};
    st[0] = 0; st[1] = 0; st[2] = 0;

    rst = 1'b1; cmd_valid = 1'b0; cmd_reload = 1'b0; cmd_x = '0;
    w_valid = 1'b0; w_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctl", CW'({cmd_ready, w_ready, preload_valid, start, res_valid, busy,
                             weights_loaded, dbg_state}), '0);
    check_eq("rst_pre", CW'({preload_addr, preload_data}), '0);
    check_eq("rst_x", CW'(x_vector_flat), '0);
    check_eq("rst_res", res_data, '0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", CW'({cmd_ready, busy}), CW'(2'b10));

    // Job 1: no reload requested, but nothing loaded yet -> forced load.
    send_cmd(1'b0, X1, acc);
    check_eq("j1_forced_load", CW'({w_ready, busy, weights_loaded}), CW'(3'b110));
    load_weights(NBEATS, 0, last);
    wait_start(40, sc);
    check_eq("j1_start_lat", CW'(sc), CW'(last + 2));
    check_eq("j1_wl", CW'(weights_loaded), CW'(1));
    compare_preload(NBEATS);
    wait_res(60, rc);
    check_eq("j1_res_lat", CW'(rc), CW'(sc + COMPUTE_LAT + 1));
    check_eq("j1_res_data", res_data, exp_res(sc, X1));
    take_res();

    // Job 2: weights kept; stray weight beats must not be consumed.
    w_valid = 1'b1;
    w_data = 8'hee;
    send_cmd(1'b0, X2, acc);
    check_eq("j2_no_wready", CW'(w_ready), CW'(0));
    wait_start(10, sc);
    check_eq("j2_start_lat", CW'(sc), CW'(acc + 2));
    wait_res(60, rc);
    w_valid = 1'b0;
    check_eq("j2_res_lat", CW'(rc), CW'(sc + COMPUTE_LAT + 1));
    compare_preload(0);

    // Result held while res_ready is low; the next command waits.
    cmd_valid = 1'b1;
    cmd_reload = 1'b1;
    cmd_x = X3;
    for (int k = 0; k < 10; k++) begin
      check_eq("hold_data", res_data, exp_res(sc, X2));
      check_eq("hold_ctl", CW'({res_valid, cmd_ready}), CW'(2'b10));
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("hs_then_ready", CW'({res_valid, cmd_ready}), CW'(2'b01));
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x = ~X3;
    check_eq("j3_load", CW'({w_ready, busy}), CW'(2'b11));

    // Job 3: explicit reload with 50% w_valid gaps.
    load_weights(NBEATS, 50, last);
    wait_start(40, sc);
    check_eq("j3_start_lat", CW'(sc), CW'(last + 2));
    compare_preload(NBEATS);
    wait_res(60, rc);
    check_eq("j3_res_data", res_data, exp_res(sc, X3));
    take_res();

    // Job 4: asynchronous reset after 80 weight beats.
    send_cmd(1'b1, X4, acc);
    load_weights(80, 0, last);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_ctl", CW'({cmd_ready, w_ready, preload_valid, start, res_valid, busy,
                              weights_loaded}), '0);
    check_eq("arst_data", CW'({preload_addr, preload_data}), '0);
    compare_preload(80);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst", CW'({cmd_ready, weights_loaded, busy}), CW'(3'b100));

    // Job 5: reload not requested, forced after reset.
    send_cmd(1'b0, X5, acc);
    check_eq("j5_forced_load", CW'({w_ready, busy}), CW'(2'b11));
    load_weights(NBEATS, 0, last);
    wait_start(40, sc);
    check_eq("j5_start_lat", CW'(sc), CW'(last + 2));
    compare_preload(NBEATS);
    wait_res(60, rc);
    check_eq("j5_res_data", res_data, exp_res(sc, X5));
    take_res();

    // Back-to-back jobs: res_ready tied high, cmd_valid held high.
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_reload = 1'b0;
    cmd_x = bb_x[0];
    n_acc = 0; n_st = 0; n_res = 0; acc_flag = 1'b0;
    for (int c = 0; c < 200 && n_res < 3; c++) begin
      if (acc_flag) begin
        acc_flag = 1'b0;
        if (n_acc < 3) cmd_x = bb_x[n_acc];
        else cmd_valid = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        acc_flag = 1'b1;
      end
      if (start && n_st < 3) begin
        st[n_st] = cyc;
        n_st++;
      end
      if (res_valid && n_res < 3 && n_res < n_st) begin
        check_eq("bb_res_lat", CW'(cyc), CW'(st[n_res] + COMPUTE_LAT + 1));
        check_eq("bb_res_data", res_data, exp_res(st[n_res], bb_x[n_res]));
        n_res++;
      end
      @(negedge clk);
    end
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    check_eq("bb_count", CW'(n_res), CW'(3));
    // Result handshake, one idle accept cycle, one settle cycle, then start.
    check_eq("bb_spacing0", CW'(st[1] - st[0]), CW'(COMPUTE_LAT + 4));
    check_eq("bb_spacing1", CW'(st[2] - st[1]), CW'(COMPUTE_LAT + 4));

    check_eq("no_overlap", CW'(overlap_cnt), CW'(0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
